// File: rtl/dff_delay_line_tapped.sv
// Enable-gated DFF delay line with per-stage valid bits, a runtime tap mux,
// synchronous flush and an incrementally maintained occupancy counter.
module dff_delay_line_tapped #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int TAP_W = 3,
    parameter int CNT_W = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             en,
    input  logic             flush,
    input  logic [WIDTH-1:0] in,
    input  logic             in_valid,
    input  logic [TAP_W-1:0] tap_sel,
    output logic [WIDTH-1:0] tap_out,
    output logic             tap_valid,
    output logic             tap_err,
    output logic [WIDTH-1:0] last_out,
    output logic             last_valid,
    output logic [CNT_W-1:0] fill_cnt,
    output logic             full
);

    localparam logic [TAP_W:0] DEPTH_L = (TAP_W+1)'(DEPTH);

    logic [WIDTH-1:0] d_q [DEPTH];
    logic [WIDTH-1:0] d_d [DEPTH];
    logic [DEPTH-1:0] v_q, v_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        d_d   = d_q;
        v_d   = v_q;
        cnt_d = cnt_q;
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) d_d[i] = '0;
            v_d   = '0;
            cnt_d = '0;
        end else if (en) begin
            d_d[0] = in;
            for (int i = 1; i < DEPTH; i++) d_d[i] = d_q[i-1];
            v_d = {v_q[DEPTH-2:0], in_valid};
            // Entering and leaving valids cancel, so cnt stays within 0..DEPTH
            cnt_d = cnt_q + CNT_W'(in_valid) - CNT_W'(v_q[DEPTH-1]);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) d_q[i] <= '0;
            v_q   <= '0;
            cnt_q <= '0;
        end else begin
            d_q   <= d_d;
            v_q   <= v_d;
            cnt_q <= cnt_d;
        end
    end

    // Out-of-range selects fall back to the last stage
    always_comb begin
        tap_err   = ({1'b0, tap_sel} >= DEPTH_L);
        tap_out   = d_q[DEPTH-1];
        tap_valid = v_q[DEPTH-1];
        for (int i = 0; i < DEPTH; i++) begin
            if ({1'b0, tap_sel} == (TAP_W+1)'(i)) begin
                tap_out   = d_q[i];
                tap_valid = v_q[i];
            end
        end
    end

    assign last_out   = d_q[DEPTH-1];
    assign last_valid = v_q[DEPTH-1];
    assign fill_cnt   = cnt_q;
    assign full       = (cnt_q == CNT_W'(DEPTH));

endmodule

// File: tb/tb_dff_delay_line_tapped.sv
// Bench for dff_delay_line_tapped: DEPTH=4 and DEPTH=6 instances driven in
// parallel, checked by vector table, directed sequences and a queue model.
module tb_dff_delay_line_tapped;

    logic       CLK = 1'b0;
    logic       RST;
    logic       en, flush, in_valid;
    logic [7:0] din;
    logic [2:0] tap_sel;

    logic [7:0] t4_out, l4_out, t6_out, l6_out;
    logic       t4_v, t4_err, l4_v, f4_full;
    logic       t6_v, t6_err, l6_v, f6_full;
    logic [3:0] f4_cnt, f6_cnt;

    always #5 CLK = ~CLK;

    dff_delay_line_tapped #(.WIDTH(8), .DEPTH(4), .TAP_W(3), .CNT_W(4)) u4 (
        .CLK(CLK), .RST(RST), .en(en), .flush(flush), .in(din),
        .in_valid(in_valid), .tap_sel(tap_sel), .tap_out(t4_out),
        .tap_valid(t4_v), .tap_err(t4_err), .last_out(l4_out),
        .last_valid(l4_v), .fill_cnt(f4_cnt), .full(f4_full)
    );

    dff_delay_line_tapped #(.WIDTH(8), .DEPTH(6), .TAP_W(3), .CNT_W(4)) u6 (
        .CLK(CLK), .RST(RST), .en(en), .flush(flush), .in(din),
        .in_valid(in_valid), .tap_sel(tap_sel), .tap_out(t6_out),
        .tap_valid(t6_v), .tap_err(t6_err), .last_out(l6_out),
        .last_valid(l6_v), .fill_cnt(f6_cnt), .full(f6_full)
    );

    typedef struct packed {
        logic [7:0] tap;
        logic       tapv;
        logic       err;
        logic [7:0] last;
        logic       lastv;
        logic [3:0] fill;
        logic       full;
    } obs_t;

    typedef struct packed {
        logic [7:0] d;
        logic       v;
    } smp_t;

    typedef struct {
        logic       en;
        logic       flush;
        logic [7:0] din;
        logic       vin;
        logic [7:0] etap;
        logic       etapv;
        logic [7:0] elast;
        logic       elv;
        logic [3:0] efill;
        logic       efull;
    } vec_t;

    smp_t h4[$];
    smp_t h6[$];
    vec_t vt[$];
    int   checks   = 0;
    int   failures = 0;
    obs_t o4, o6;

    assign o4 = {t4_out, t4_v, t4_err, l4_out, l4_v, f4_cnt, f4_full};
    assign o6 = {t6_out, t6_v, t6_err, l6_out, l6_v, f6_cnt, f6_full};

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Stage t holds the sample captured t enabled edges ago; older is zero.
    function automatic smp_t stage(input smp_t q[$], input int t);
        smp_t s;
        s = '0;
        if (t < q.size()) s = q[t];
        return s;
    endfunction

    function automatic obs_t model(input smp_t q[$], input int depth,
                                   input logic [2:0] sel);
        obs_t o;
        smp_t s;
        int   n;
        int   t;
        o = '0;
        n = 0;
        for (int i = 0; i < depth; i++) begin
            s = stage(q, i);
            if (s.v) n++;
        end
        t       = (int'(sel) < depth) ? int'(sel) : depth - 1;
        s       = stage(q, t);
        o.tap   = s.d;
        o.tapv  = s.v;
        o.err   = (int'(sel) >= depth);
        s       = stage(q, depth - 1);
        o.last  = s.d;
        o.lastv = s.v;
        o.fill  = 4'(n);
        o.full  = (n == depth);
        return o;
    endfunction

    task automatic mdl_edge();
        if (flush) begin
            h4.delete();
            h6.delete();
        end else if (en) begin
            h4.push_front({din, in_valid});
            h6.push_front({din, in_valid});
            if (h4.size() > 4) void'(h4.pop_back());
            if (h6.size() > 6) void'(h6.pop_back());
        end
    endtask

    task automatic step();
        @(posedge CLK);
        mdl_edge();
        #1;
    endtask

    task automatic check_all(input string tag);
        chk({tag, "/d4"}, 32'(o4), 32'(model(h4, 4, tap_sel)));
        chk({tag, "/d6"}, 32'(o6), 32'(model(h6, 6, tap_sel)));
    endtask

    function automatic vec_t mk(input logic e, input logic f,
                                input logic [7:0] d, input logic v,
                                input logic [7:0] tp, input logic tv,
                                input logic [7:0] la, input logic lv,
                                input logic [3:0] fc, input logic fu);
        vec_t r;
        r.en = e; r.flush = f; r.din = d; r.vin = v;
        r.etap = tp; r.etapv = tv; r.elast = la; r.elv = lv;
        r.efill = fc; r.efull = fu;
        return r;
    endfunction

    localparam int FLUSH_ROW = 8;

    initial begin
        obs_t z;
        RST = 1'b1; en = 1'b0; flush = 1'b0; in_valid = 1'b0;
        din = '0; tap_sel = '0;

        // tap_sel = 1 on the DEPTH=4 instance throughout the table
        vt.push_back(mk(1, 0, 8'h11, 1, 8'h00, 0, 8'h00, 0, 4'd1, 0));
        vt.push_back(mk(1, 0, 8'h22, 1, 8'h11, 1, 8'h00, 0, 4'd2, 0));
        vt.push_back(mk(1, 0, 8'h33, 1, 8'h22, 1, 8'h00, 0, 4'd3, 0));
        vt.push_back(mk(1, 0, 8'h44, 1, 8'h33, 1, 8'h11, 1, 4'd4, 1));
        vt.push_back(mk(0, 0, 8'h99, 1, 8'h33, 1, 8'h11, 1, 4'd4, 1));
        vt.push_back(mk(0, 0, 8'h98, 0, 8'h33, 1, 8'h11, 1, 4'd4, 1));
        vt.push_back(mk(0, 0, 8'h97, 1, 8'h33, 1, 8'h11, 1, 4'd4, 1));
        vt.push_back(mk(1, 0, 8'h55, 1, 8'h44, 1, 8'h22, 1, 4'd4, 1));
        vt.push_back(mk(1, 1, 8'hFF, 1, 8'h00, 0, 8'h00, 0, 4'd0, 0));
        vt.push_back(mk(1, 0, 8'hA0, 1, 8'h00, 0, 8'h00, 0, 4'd1, 0));
        vt.push_back(mk(1, 0, 8'hA1, 0, 8'hA0, 1, 8'h00, 0, 4'd1, 0));
        vt.push_back(mk(1, 0, 8'hA2, 1, 8'hA1, 0, 8'h00, 0, 4'd2, 0));
        vt.push_back(mk(1, 0, 8'hA3, 0, 8'hA2, 1, 8'hA0, 1, 4'd2, 0));
        vt.push_back(mk(1, 0, 8'hB0, 0, 8'hA3, 0, 8'hA1, 0, 4'd1, 0));
        vt.push_back(mk(1, 0, 8'hB1, 0, 8'hB0, 0, 8'hA2, 1, 4'd1, 0));
        vt.push_back(mk(1, 0, 8'hB2, 0, 8'hB1, 0, 8'hA3, 0, 4'd0, 0));
        vt.push_back(mk(1, 0, 8'hB3, 0, 8'hB2, 0, 8'hB0, 0, 4'd0, 0));

        #12;
        chk("rst_hold_d4", 32'(o4), 32'(0));
        chk("rst_hold_d6", 32'(o6), 32'(0));
        @(negedge CLK);
        RST = 1'b0;

        en = 1'b1; in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            din = 8'h5A + 8'(k);
            step();
            check_all("preload");
        end

        // Asynchronous reset between edges, tap_sel out of range
        tap_sel = 3'd7;
        #2 RST = 1'b1;
        h4.delete();
        h6.delete();
        #1;
        z = '0;
        z.err = 1'b1;
        chk("rst_async_d4", 32'(o4), 32'(z));
        chk("rst_async_d6", 32'(o6), 32'(z));
        @(negedge CLK);
        RST = 1'b0;
        tap_sel = 3'd0;
        en = 1'b0;
        din = 8'hEE;
        for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("idle%0d_d4", k), 32'(o4), 32'(0));
            chk($sformatf("idle%0d_d6", k), 32'(o6), 32'(0));
        end

        tap_sel = 3'd1;
        foreach (vt[i]) begin
            en = vt[i].en; flush = vt[i].flush;
            din = vt[i].din; in_valid = vt[i].vin;
            step();
            chk($sformatf("vec%0d", i),
                32'({t4_out, t4_v, l4_out, l4_v, f4_cnt, f4_full}),
                32'({vt[i].etap, vt[i].etapv, vt[i].elast, vt[i].elv,
                     vt[i].efill, vt[i].efull}));
            check_all($sformatf("vec%0d", i));
            if (i == FLUSH_ROW) begin
                for (int s = 0; s < 4; s++) begin
                    tap_sel = 3'(s);
                    #1;
                    chk($sformatf("flush_tap%0d", s), 32'({t4_out, t4_v}), 32'(0));
                end
                tap_sel = 3'd1;
            end
        end
        flush = 1'b0;

        en = 1'b1; in_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            din = 8'hC0 + 8'(k);
            step();
        end
        for (int s = 0; s < 8; s++) begin
            tap_sel = 3'(s);
            #1;
            chk($sformatf("sweep_err%0d", s), 32'(t6_err), 32'(s >= 6));
            chk($sformatf("sweep_v%0d", s), 32'(t6_v), 32'(1));
            if (s >= 6)
                chk($sformatf("sweep_tap%0d", s), 32'(t6_out), 32'(l6_out));
            chk($sformatf("sweep_dat%0d", s), 32'(t6_out),
                32'((s >= 6) ? 8'hC0 : 8'(8'hC5 - 8'(s))));
            check_all($sformatf("sweep%0d", s));
        end

        for (int k = 0; k < 1000; k++) begin
            en       = ($urandom_range(0, 3) != 0);
            flush    = ($urandom_range(0, 31) == 0);
            din      = 8'($urandom);
            in_valid = 1'($urandom);
            tap_sel  = 3'($urandom);
            step();
            check_all($sformatf("rnd%0d", k));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
